l2spm_arbiter: RTL and testbench

L2SPM_ARBITER -- requirements
Module: l2spm_arbiter

---
 rtl/l2spm_arbiter.sv | 111 +++++++++++
 tb/tb_l2spm_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2spm_arbiter.sv
// Round-robin arbiter with exclusive-hold lock in front of a single-port, 1-cycle-latency L2 scratchpad SRAM.
// Define L2SPM_ARB_CONFLICT_CNT_EN to build the saturating stall-cycle counter; otherwise conflict_cnt_o is 0.
module l2spm_arbiter #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 12,
  parameter int DataWidth = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0]                     lock_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i,
  output logic [31:0]                           conflict_cnt_o
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e       state_q;
  idx_t              owner_q, ptr_q, gnt_idx;
  logic              gnt_any;
  logic [NumReq-1:0] rvalid_q;

  function automatic idx_t wrap_inc(idx_t i);
    return (int'(i) == NumReq - 1) ? '0 : idx_t'(int'(i) + 1);
  endfunction

  // ptr_q is the highest-priority index; scan forward from it and take the first requester.
  always_comb begin
    idx_t k;
    k       = '0;
    gnt_o   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (state_q == LOCKED) begin
      if (req_i[owner_q]) begin
        gnt_o[owner_q] = 1'b1;
        gnt_idx        = owner_q;
        gnt_any        = 1'b1;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        k = idx_t'((int'(ptr_q) + i) % NumReq);
        if (!gnt_any && req_i[k]) begin
          gnt_o[k] = 1'b1;
          gnt_idx  = k;
          gnt_any  = 1'b1;
        end
      end
    end
  end

  assign mem_req_o   = gnt_any;
  assign mem_we_o    = we_i[gnt_idx];
  assign mem_addr_o  = addr_i[gnt_idx];
  assign mem_wdata_o = wdata_i[gnt_idx];
  assign mem_be_o    = be_i[gnt_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= UNLOCKED;
      owner_q  <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o & ~we_i;
      if (state_q == UNLOCKED) begin
        if (gnt_any) begin
          ptr_q <= wrap_inc(gnt_idx);
          if (lock_i[gnt_idx]) begin
            state_q <= LOCKED;
            owner_q <= gnt_idx;
          end
        end
      end else if (!lock_i[owner_q]) begin
        // While locked a grant implies req_i[owner], so either release condition reduces to !lock.
        state_q <= UNLOCKED;
        ptr_q   <= wrap_inc(owner_q);
      end
    end
  end

  assign rvalid_o = rvalid_q & {NumReq{~rst_i}};
  assign rdata_o  = mem_rdata_i;

`ifdef L2SPM_ARB_CONFLICT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else if (|(req_i & ~gnt_o) && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
  end

  assign conflict_cnt_o = rst_i ? '0 : cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2spm_arbiter.sv
// Self-checking bench for l2spm_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_l2spm_arbiter;
  localparam int N = 2, AW = 12, DW = 64, BW = DW / 8;

  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, lock = '0, we = '0;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][DW-1:0] wdata = '0;
  logic [N-1:0][BW-1:0] be = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  l2spm_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .conflict_cnt_o(cnt)
  );

  // SRAM environment: 1-cycle read latency, byte-enabled writes
  logic [DW-1:0] sram [0:4095];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++) if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model state
  int m_ptr = 0, m_owner = 0;
  bit m_locked = 0;
  logic [N-1:0] m_rv = '0;
  logic [DW-1:0] m_rd = '0;
  longint m_cnt = 0;
  logic [DW-1:0] mdl_mem [0:4095];

  logic [N-1:0] obs_gnt, obs_rv;
  logic [DW-1:0] obs_rdata;
  logic [31:0] obs_cnt;
  int n_chk = 0, n_fail = 0;

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_locked) begin
      if (req[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Entered just after a rising edge with inputs already driven; checks mid-cycle, then advances the model.
  task automatic step(input string tag);
    logic [N-1:0] eg, erv;
    logic [31:0] ecnt;
    int gi;
    #3;
    eg = model_gnt();
    erv = rst ? '0 : m_rv;
    ecnt = rst ? 32'd0 : 32'(m_cnt);
    gi = 0;
    for (int i = 0; i < N; i++) if (eg[i]) gi = i;
    obs_gnt = gnt; obs_rv = rvalid; obs_rdata = rdata; obs_cnt = cnt;
    n_chk++;
    if (gnt !== eg) begin n_fail++; $display("FAIL %s gnt: got %b want %b", tag, gnt, eg); end
    n_chk++;
    if (mem_req !== (eg != '0)) begin n_fail++; $display("FAIL %s mem_req: got %b want %b", tag, mem_req, eg != '0); end
    if (eg != '0) begin
      n_chk++;
      if ({mem_we, mem_addr, mem_wdata, mem_be} !== {we[gi], addr[gi], wdata[gi], be[gi]}) begin
        n_fail++;
        $display("FAIL %s mem_fields: got we=%b a=%h d=%h be=%h want req %0d", tag, mem_we, mem_addr, mem_wdata, mem_be, gi);
      end
    end
    n_chk++;
    if (rvalid !== erv) begin n_fail++; $display("FAIL %s rvalid: got %b want %b", tag, rvalid, erv); end
    if (erv != '0) begin
      n_chk++;
      if (rdata !== m_rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", tag, rdata, m_rd); end
    end
    n_chk++;
    if (cnt !== ecnt) begin n_fail++; $display("FAIL %s conflict_cnt: got %h want %h", tag, cnt, ecnt); end
    @(posedge clk);
    if (eg != '0) begin
      if (we[gi]) begin
        for (int b = 0; b < BW; b++) if (be[gi][b]) mdl_mem[addr[gi]][b*8 +: 8] = wdata[gi][b*8 +: 8];
      end else m_rd = mdl_mem[addr[gi]];
    end
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_owner = 0; m_rv = '0; m_cnt = 0;
    end else begin
      m_rv = eg & ~we;
`ifdef L2SPM_ARB_CONFLICT_CNT_EN
      if ((req & ~eg) != '0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
`endif
      if (!m_locked) begin
        if (eg != '0) begin
          m_ptr = (gi + 1) % N;
          if (lock[gi]) begin m_locked = 1; m_owner = gi; end
        end
      end else if ((eg[m_owner] && !lock[m_owner]) || (!req[m_owner] && !lock[m_owner])) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
    req = r; lock = l; we = w;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive('0, '0, '0);
    step("reset");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive('0, '0, '0);
    step("rst_idle");
    drive(2'b11, '0, '0);
    step("rst_req");
    n_chk++;
    if (obs_gnt !== 2'b01 || obs_rv !== '0 || obs_cnt !== '0) begin
      n_fail++; $display("FAIL reset_state: got gnt=%b rv=%b cnt=%h want 01/00/0", obs_gnt, obs_rv, obs_cnt);
    end
    rst = 1'b0; drive('0, '0, '0);
    step("post_rst");
    n_chk++;
    if (obs_rv !== '0) begin n_fail++; $display("FAIL post_reset_rvalid: got %b want 00", obs_rv); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    addr[0] = 12'h010; addr[1] = 12'h020;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, '0, '0);
      step("rr");
      n_chk++;
      if (obs_gnt !== exp_seq[i]) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", i, obs_gnt, exp_seq[i]); end
    end
    drive('0, '0, '0);
    step("rr_tail");
    n_chk++;
    if (obs_rv !== 2'b10) begin n_fail++; $display("FAIL rr_last_rvalid: got %b want 10", obs_rv); end
    n_chk++;
`ifdef L2SPM_ARB_CONFLICT_CNT_EN
    if (obs_cnt !== 32'd4) begin n_fail++; $display("FAIL rr_cnt: got %0d want 4", obs_cnt); end
`else
    if (obs_cnt !== 32'd0) begin n_fail++; $display("FAIL rr_cnt: got %0d want 0", obs_cnt); end
`endif
  endtask

  task automatic test_write_read();
    do_reset();
    addr[0] = 12'h0A5; wdata[0] = 64'hDEAD_BEEF_0123_4567; be[0] = 8'hFF;
    drive(2'b01, '0, 2'b01); step("wr_full");
    addr[0] = 12'h0A6; wdata[0] = 64'h1111_2222_3333_4444; be[0] = 8'h0F;
    drive(2'b01, '0, 2'b01); step("wr_part");
    n_chk++;
    if (obs_rv !== '0) begin n_fail++; $display("FAIL write_rvalid: got %b want 00", obs_rv); end
    addr[0] = 12'h0A5; drive(2'b01, '0, '0); step("rd_full");
    addr[0] = 12'h0A6; drive(2'b01, '0, '0); step("rd_part");
    n_chk++;
    if (obs_rv !== 2'b01 || obs_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL read_full: got rv=%b d=%h want 01 deadbeef01234567", obs_rv, obs_rdata);
    end
    drive('0, '0, '0); step("rd_tail");
    n_chk++;
    if (obs_rv !== 2'b01 || obs_rdata !== 64'h0000_0000_3333_4444) begin
      n_fail++; $display("FAIL read_part: got rv=%b d=%h want 01 0000000033334444", obs_rv, obs_rdata);
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(2'b10, 2'b10, '0); step("lk_take");
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b10, '0); step("lk_hold");
      n_chk++;
      if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL lock_hold%0d: got %b want 10", i, obs_gnt); end
    end
    drive(2'b11, '0, '0); step("lk_rel");
    n_chk++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL lock_release: got %b want 10", obs_gnt); end
    drive(2'b11, '0, '0); step("lk_after");
    n_chk++;
    if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL lock_after: got %b want 01", obs_gnt); end
    drive(2'b01, 2'b01, '0); step("lk_take0");
    drive('0, '0, '0); step("lk_idle_rel");
    drive(2'b11, '0, '0); step("lk_idle_after");
    n_chk++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL idle_release: got %b want 10", obs_gnt); end
  endtask

  task automatic test_reset_locked();
    do_reset();
    drive(2'b10, 2'b10, '0); step("rl_take");
    rst = 1'b1; drive('0, '0, '0); step("rl_rst");
    rst = 1'b0; drive(2'b11, '0, '0); step("rl_after");
    n_chk++;
    if (obs_gnt !== 2'b01 || obs_rv !== '0) begin
      n_fail++; $display("FAIL reset_locked: got gnt=%b rv=%b want 01/00", obs_gnt, obs_rv);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) begin
        req[k] = $urandom_range(0, 3) != 0;
        lock[k] = $urandom_range(0, 3) == 0;
        we[k] = $urandom_range(0, 1) != 0;
        addr[k] = AW'($urandom_range(0, 15));
        wdata[k] = {$urandom, $urandom};
        be[k] = BW'($urandom);
      end
      step("rand");
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
`ifdef L2SPM_ARB_CONFLICT_CNT_EN
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 64'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, '0, '0); step("sat");
    end
    drive('0, '0, '0); step("sat_tail");
    n_chk++;
`ifdef L2SPM_ARB_CONFLICT_CNT_EN
    if (obs_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL saturate: got %h want ffffffff", obs_cnt); end
`else
    if (obs_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_disabled: got %h want 0", obs_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i] = '0;
      mdl_mem[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock();
    test_reset_locked();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
